fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 8-bit pipelined processor. It holds the program counter, drives the instruction-memory address, and registers the 24-bit instruction and its address into the IF/ID pipeline register consumed by decode. It also performs redirects (taken branch, interrupt entry, return-from-interrupt) and handles stalls. It accepts one interrupt at a time and stores the return address in an internal EPC.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INS_W, 24, instruction width
- RESET_VEC, 8'h00, PC value after reset
- INT_VEC, 8'hF0, interrupt service routine entry address

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- interrupt  in  1  external interrupt request, asynchronous level
- stall  in  1  hold PC and IF/ID register (from hazard logic)
- branch_taken  in  1  redirect request from decode
- branch_target  in  ADDR_W  redirect address, valid with branch_taken
- reti  in  1  return-from-interrupt decoded this cycle
- imem_addr  out  ADDR_W  instruction-memory address (= PC, combinational)
- imem_data  in  INS_W  instruction-memory read data, combinational from imem_addr
- ins  out  INS_W  IF/ID instruction
- Current_Address  out  ADDR_W  address of ins
- ins_valid  out  1  ins is a real instruction (0 = bubble)
- int_ack  out  1  one-cycle pulse on interrupt acceptance
- in_isr  out  1  ISR state indicator
- epc  out  ADDR_W  saved return address

## Operation
- State machine has two states, RUN and ISR. Reset enters RUN.
- Interrupt path: interrupt passes through a 2-flop synchronizer (s1, s2). The rising edge s2 & ~s2_d sets `pending`. `pending` is cleared only on acceptance or reset.
- Per-edge priority, highest first: reset > branch_taken > reti > interrupt accept > stall > normal fetch.
- Normal fetch:
  - ins <= imem_data, Current_Address <= PC, ins_valid <= 1.
  - PC <= PC+1, modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
- stall: PC, ins, Current_Address and ins_valid all hold. stall does not block branch_taken or reti.
- branch_taken: PC <= branch_target. IF/ID becomes a bubble: ins <= 0, ins_valid <= 0, Current_Address holds.
- reti:
  - Honoured only in ISR: PC <= epc, bubble inserted, state -> RUN.
  - In RUN, reti is ignored. The fetch proceeds as if reti were 0.
- Interrupt accept:
  - Condition: state RUN, pending=1, no branch_taken, no stall.
  - Actions: epc <= PC, PC <= INT_VEC, bubble inserted, int_ack=1 for one cycle, pending cleared, state -> ISR.
- In ISR, new edges set pending, but no acceptance occurs (no nesting). After reti, a still-set pending is accepted at the first eligible cycle.
- Branch in the same cycle as an eligible interrupt: the branch wins and pending stays set. The interrupt is accepted on the next eligible edge with epc = branch_target.
- Reset mid-ISR: returns to RUN, pending cleared, synchronizer cleared.

## Timing
- Reset values:
  - Registered outputs: ins=0, Current_Address=0, ins_valid=0, int_ack=0, in_isr=0, epc=0.
  - PC=RESET_VEC, so imem_addr=RESET_VEC.
  - Internal flops: pending=0, s1=0, s2=0, s2_d=0.
- Fetch latency: one cycle. imem_addr=X during cycle n gives ins=mem[X] and Current_Address=X after edge n.
- First instruction after reset: mem[RESET_VEC] appears after the first non-reset edge.
- Redirect penalty: exactly one bubble cycle (ins_valid=0). The target instruction appears on the following edge.
- Interrupt latency, with interrupt sampled high at edge k and no blocking: s2=1 at k+1, pending=1 at k+2, acceptance at k+3 (int_ack high for cycle k+3..k+4). mem[INT_VEC] appears at k+4.
- An interrupt pulse must be at least one clk period wide to be detected.
- Throughput: one instruction per cycle absent stall or redirect.

## Test plan
- Reset then run from mem[i]=i+0x10: after reset drops, ins = 0x10, 0x11, 0x12… and Current_Address = 0, 1, 2…, with ins_valid=1 each cycle.
- Stall for 3 cycles at PC=5 → ins and Current_Address hold at address 4. On release, mem[5] appears at Current_Address=5 with no skip or duplicate.
- branch_taken with target 0x40 while stall=1 → one bubble (ins=0, ins_valid=0), then Current_Address=0x40. PC 0xFF without branch → wraps to 0x00.
- interrupt raised at PC=0x08 → int_ack pulses at k+3, epc=PC at acceptance, in_isr=1, then Current_Address=0xF0. reti → bubble, then fetch resumes at epc, in_isr=0.
- Second interrupt edge during ISR → not taken. Taken right after reti (int_ack pulses again). reti issued in RUN → ignored, PC continues.
- Interrupt coincident with branch_taken → branch wins, interrupt accepted next cycle with epc = branch_target. Reset asserted in ISR → in_isr=0, epc=0, no pending interrupt taken afterwards.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID register, redirects
// (branch, interrupt entry, return-from-interrupt), stall handling,
// single-level interrupt acceptance with a saved return address (EPC).
module fetch_stage #(
    parameter int                ADDR_W    = 8,
    parameter int                INS_W     = 24,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'('h00),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'('hF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              reti,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_data,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] Current_Address,
    output logic              ins_valid,
    output logic              int_ack,
    output logic              in_isr,
    output logic [ADDR_W-1:0] epc
);

    typedef enum logic {RUN = 1'b0, ISR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INS_W-1:0]  ins_q, ins_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              ins_valid_q, ins_valid_d;
    logic              int_ack_q, int_ack_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              pending_q, pending_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              s2_dly_q, s2_dly_d;
    logic              int_rise;

    // Next-state: synchronizer, edge capture, and the prioritised PC/IF-ID update
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        cur_addr_d  = cur_addr_q;
        ins_valid_d = ins_valid_q;
        int_ack_d   = 1'b0;
        epc_d       = epc_q;
        s1_d        = interrupt;
        s2_d        = s1_q;
        s2_dly_d    = s2_q;
        int_rise    = s2_q & ~s2_dly_q;
        pending_d   = pending_q | int_rise;

        if (branch_taken) begin
            // Redirect from decode wins over everything, including stall;
            // a pending interrupt simply waits for the next eligible edge.
            pc_d        = branch_target;
            ins_d       = '0;
            ins_valid_d = 1'b0;
        end else if (reti && (state_q == ISR)) begin
            pc_d        = epc_q;
            ins_d       = '0;
            ins_valid_d = 1'b0;
            state_d     = RUN;
        end else if ((state_q == RUN) && pending_q && !stall) begin
            // Accept: the not-yet-fetched PC is the return address.
            epc_d       = pc_q;
            pc_d        = INT_VEC;
            ins_d       = '0;
            ins_valid_d = 1'b0;
            int_ack_d   = 1'b1;
            pending_d   = 1'b0;
            state_d     = ISR;
        end else if (stall) begin
            // Hold PC and IF/ID as they are.
            pc_d = pc_q;
        end else begin
            ins_d       = imem_data;
            cur_addr_d  = pc_q;
            ins_valid_d = 1'b1;
            pc_d        = pc_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_VEC;
            ins_q       <= '0;
            cur_addr_q  <= '0;
            ins_valid_q <= 1'b0;
            int_ack_q   <= 1'b0;
            epc_q       <= '0;
            pending_q   <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s2_dly_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            cur_addr_q  <= cur_addr_d;
            ins_valid_q <= ins_valid_d;
            int_ack_q   <= int_ack_d;
            epc_q       <= epc_d;
            pending_q   <= pending_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s2_dly_q    <= s2_dly_d;
        end
    end

    assign imem_addr       = pc_q;
    assign ins             = ins_q;
    assign Current_Address = cur_addr_q;
    assign ins_valid       = ins_valid_q;
    assign int_ack         = int_ack_q;
    assign in_isr          = (state_q == ISR);
    assign epc             = epc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory is mem[a] = a + 0x10.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        reti;
    logic [7:0]  imem_addr;
    logic [23:0] imem_data;
    logic [23:0] ins;
    logic [7:0]  Current_Address;
    logic        ins_valid;
    logic        int_ack;
    logic        in_isr;
    logic [7:0]  epc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .interrupt       (interrupt),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .reti            (reti),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .ins             (ins),
        .Current_Address (Current_Address),
        .ins_valid       (ins_valid),
        .int_ack         (int_ack),
        .in_isr          (in_isr),
        .epc             (epc)
    );

    always #5 clk = ~clk;

    assign imem_data = 24'(imem_addr) + 24'h10;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [7:0] addr);
        chk({tag, " addr"},  32'(Current_Address), 32'(addr));
        chk({tag, " ins"},   32'(ins), 32'(24'(addr) + 24'h10));
        chk({tag, " valid"}, 32'(ins_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b1; interrupt = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00; reti = 1'b0;
        step(); step();
        chk("rst ins",   32'(ins), 32'h0);
        chk("rst addr",  32'(Current_Address), 32'h0);
        chk("rst valid", 32'(ins_valid), 32'h0);
        chk("rst ack",   32'(int_ack), 32'h0);
        chk("rst isr",   32'(in_isr), 32'h0);
        chk("rst epc",   32'(epc), 32'h0);
        chk("rst pc",    32'(imem_addr), 32'h0);

        // Sequential fetch from RESET_VEC
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_fetch($sformatf("seq%0d", i), 8'(i));
        end

        // Stall three cycles with PC=5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_fetch($sformatf("stall%0d", i), 8'h04);
            chk("stall pc", 32'(imem_addr), 32'h05);
        end
        stall = 1'b0;
        step(); chk_fetch("unstall", 8'h05);

        // Branch during stall: bubble, then target
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        chk("br ins",   32'(ins), 32'h0);
        chk("br valid", 32'(ins_valid), 32'h0);
        chk("br hold",  32'(Current_Address), 32'h05);
        chk("br pc",    32'(imem_addr), 32'h40);
        stall = 1'b0; branch_taken = 1'b0;
        step(); chk_fetch("br tgt", 8'h40);

        // PC wrap 0xFF -> 0x00
        branch_taken = 1'b1; branch_target = 8'hFE;
        step(); branch_taken = 1'b0;
        step(); chk_fetch("wrap fe", 8'hFE);
        step(); chk_fetch("wrap ff", 8'hFF);
        chk("wrap pc", 32'(imem_addr), 32'h00);
        step(); chk_fetch("wrap 00", 8'h00);

        // Interrupt raised with PC=0x08 (edge k samples it)
        branch_taken = 1'b1; branch_target = 8'h08;
        step(); branch_taken = 1'b0; interrupt = 1'b1;
        step(); chk_fetch("irq k", 8'h08); interrupt = 1'b0;
        step(); chk_fetch("irq k1", 8'h09);
        step(); chk_fetch("irq k2", 8'h0A);
        chk("irq k2 ack", 32'(int_ack), 32'h0);
        step();
        chk("irq k3 ack",   32'(int_ack), 32'h1);
        chk("irq k3 epc",   32'(epc), 32'h0B);
        chk("irq k3 isr",   32'(in_isr), 32'h1);
        chk("irq k3 valid", 32'(ins_valid), 32'h0);
        chk("irq k3 pc",    32'(imem_addr), 32'hF0);
        step(); chk_fetch("isr f0", 8'hF0);
        chk("isr ack drop", 32'(int_ack), 32'h0);
        step(); chk_fetch("isr f1", 8'hF1);

        // Second interrupt edge inside the ISR: not nested
        interrupt = 1'b1;
        step(); interrupt = 1'b0;
        step(); step(); step();
        chk_fetch("nest f5", 8'hF5);
        chk("nest ack", 32'(int_ack), 32'h0);
        chk("nest isr", 32'(in_isr), 32'h1);

        // reti: back to epc, then the still-pending interrupt is accepted
        reti = 1'b1;
        step(); reti = 1'b0;
        chk("reti valid", 32'(ins_valid), 32'h0);
        chk("reti isr",   32'(in_isr), 32'h0);
        chk("reti pc",    32'(imem_addr), 32'h0B);
        chk("reti hold",  32'(Current_Address), 32'hF5);
        step();
        chk("re-acc ack", 32'(int_ack), 32'h1);
        chk("re-acc isr", 32'(in_isr), 32'h1);
        chk("re-acc epc", 32'(epc), 32'h0B);
        chk("re-acc pc",  32'(imem_addr), 32'hF0);
        step(); chk_fetch("re-isr f0", 8'hF0);
        chk("re-isr ack", 32'(int_ack), 32'h0);

        // Plain reti, then resume at epc
        reti = 1'b1;
        step(); reti = 1'b0;
        chk("reti2 valid", 32'(ins_valid), 32'h0);
        chk("reti2 isr",   32'(in_isr), 32'h0);
        step(); chk_fetch("resume", 8'h0B);

        // reti while in RUN is ignored
        reti = 1'b1;
        step(); reti = 1'b0;
        chk_fetch("reti run", 8'h0C);
        chk("reti run isr", 32'(in_isr), 32'h0);

        // Interrupt coincident with branch: branch wins, accept next edge
        interrupt = 1'b1;
        step(); interrupt = 1'b0; chk_fetch("co k", 8'h0D);
        step(); chk_fetch("co k1", 8'h0E);
        step(); chk_fetch("co k2", 8'h0F);
        branch_taken = 1'b1; branch_target = 8'h30;
        step(); branch_taken = 1'b0;
        chk("co br ack",   32'(int_ack), 32'h0);
        chk("co br pc",    32'(imem_addr), 32'h30);
        chk("co br valid", 32'(ins_valid), 32'h0);
        chk("co br isr",   32'(in_isr), 32'h0);
        step();
        chk("co acc ack", 32'(int_ack), 32'h1);
        chk("co acc epc", 32'(epc), 32'h30);
        chk("co acc pc",  32'(imem_addr), 32'hF0);
        step(); chk_fetch("co isr", 8'hF0);

        // Reset inside ISR with an interrupt pending
        interrupt = 1'b1;
        step(); interrupt = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        chk("rst2 isr",   32'(in_isr), 32'h0);
        chk("rst2 epc",   32'(epc), 32'h0);
        chk("rst2 ack",   32'(int_ack), 32'h0);
        chk("rst2 valid", 32'(ins_valid), 32'h0);
        chk("rst2 pc",    32'(imem_addr), 32'h00);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_fetch($sformatf("post%0d", i), 8'(i));
            chk("post ack", 32'(int_ack), 32'h0);
            chk("post isr", 32'(in_isr), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
